// File: rtl/dmem_port_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_port_arbiter
//
// Shares the single data-memory port of cache_top between the core load/store
// path and a DMA/debug master. Arbitration is round-robin. A granted transaction
// owns the port until cache_top drops its stall. The core stall is regenerated
// here, and a saturating counter records the cycles a requester spent waiting.
//
// Ports
//   clk, rst          system clock; synchronous active-high reset
//   c_rd, c_wr        core load / store request (store wins if both are high)
//   c_addr, c_wdata   core word address and store data
//   c_rdata, c_stall  core load data and stall back to the datapath
//   d_req, d_we       DMA request (held until d_ack) and write/read select
//   d_addr, d_wdata   DMA word address and write data
//   d_ack, d_rdata    DMA one-cycle completion pulse and read data
//   m_read, m_write   request strobes to cache_top
//   m_addr, m_wdata   address and write data to cache_top
//   m_stall, m_rdata  miss-in-progress and read data from cache_top
//   contention        saturating count of blocked-requester cycles
// -----------------------------------------------------------------------------
module dmem_port_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              c_rd,
    input  logic              c_wr,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic [DATA_W-1:0] c_rdata,
    output logic              c_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              m_read,
    output logic              m_write,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_stall,
    input  logic [DATA_W-1:0] m_rdata,
    output logic [CNT_W-1:0]  contention
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_C = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    // lastGrant encoding: 0 = core, 1 = DMA
    localparam logic GRANT_CORE = 1'b0;
    localparam logic GRANT_DMA  = 1'b1;

    state_t              state_q, state_d;
    logic                lastGrant_q, lastGrant_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                dAck_q, dAck_d;
    logic [DATA_W-1:0]   dRdata_q, dRdata_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic                coreReq;
    logic                coreOwns;
    logic                dmaOwns;
    logic                blocked;
    logic                mRead;
    logic                mWrite;

    assign coreReq = c_rd | c_wr;

    // State register. The request registers (we/addr/wdata) serve two roles:
    // they hold the in-flight op while BUSY, and they keep m_addr/m_wdata
    // stable at their last driven value when nobody is requesting.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            lastGrant_q <= GRANT_DMA;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            dAck_q      <= 1'b0;
            dRdata_q    <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            lastGrant_q <= lastGrant_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            dAck_q      <= dAck_d;
            dRdata_q    <= dRdata_d;
            cnt_q       <= cnt_d;
        end
    end

    // Arbitration and next-state logic. In IDLE the winner's op goes straight
    // to the memory port so a hit finishes with no added latency; only a miss
    // moves us into a BUSY state, where requester inputs are ignored and the
    // latched op is replayed until cache_top releases the stall. A DMA
    // completion is acknowledged one cycle later through the registered d_ack.
    always_comb begin
        state_d     = state_q;
        lastGrant_d = lastGrant_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        dAck_d      = 1'b0;
        dRdata_d    = dRdata_q;
        coreOwns    = 1'b0;
        dmaOwns     = 1'b0;
        blocked     = 1'b0;
        mRead       = 1'b0;
        mWrite      = 1'b0;

        case (state_q)
            IDLE: begin
                // On a tie the requester that was not granted last time wins.
                if (coreReq && (!d_req || lastGrant_q == GRANT_DMA)) begin
                    coreOwns = 1'b1;
                end else if (d_req) begin
                    dmaOwns = 1'b1;
                end
                blocked = coreReq & d_req;

                if (coreOwns) begin
                    we_d    = c_wr;
                    addr_d  = c_addr;
                    wdata_d = c_wdata;
                    mWrite  = c_wr;
                    mRead   = ~c_wr;
                    if (m_stall) begin
                        state_d = BUSY_C;
                    end else begin
                        lastGrant_d = GRANT_CORE;
                    end
                end else if (dmaOwns) begin
                    we_d    = d_we;
                    addr_d  = d_addr;
                    wdata_d = d_wdata;
                    mWrite  = d_we;
                    mRead   = ~d_we;
                    if (m_stall) begin
                        state_d = BUSY_D;
                    end else begin
                        lastGrant_d = GRANT_DMA;
                        dAck_d      = 1'b1;
                        dRdata_d    = m_rdata;
                    end
                end
            end

            BUSY_C: begin
                coreOwns = 1'b1;
                blocked  = d_req;
                mWrite   = we_q;
                mRead    = ~we_q;
                if (!m_stall) begin
                    state_d     = IDLE;
                    lastGrant_d = GRANT_CORE;
                end
            end

            BUSY_D: begin
                dmaOwns = 1'b1;
                blocked = coreReq;
                mWrite  = we_q;
                mRead   = ~we_q;
                if (!m_stall) begin
                    state_d     = IDLE;
                    lastGrant_d = GRANT_DMA;
                    dAck_d      = 1'b1;
                    dRdata_d    = m_rdata;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Saturating contention counter: stops at all-ones instead of wrapping.
        cnt_d = cnt_q;
        if (blocked && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // The core only proceeds in a cycle where it owns the port and the cache
    // is not stalling; a core that has dropped its request is never stalled.
    assign c_stall    = coreReq & ~(coreOwns & ~m_stall) & ~rst;
    assign c_rdata    = m_rdata;

    assign m_read     = mRead & ~rst;
    assign m_write    = mWrite & ~rst;
    assign m_addr     = addr_d;
    assign m_wdata    = wdata_d;

    assign d_ack      = dAck_q;
    assign d_rdata    = dRdata_q;
    assign contention = cnt_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_port_arbiter
//
// Bench for dmem_port_arbiter. Two instances share the same stimulus: the main
// one with the default 16-bit counter and a second one with a 4-bit counter
// so saturation is reachable in a short run. A directed vector table covers
// the documented scenarios, a hand-written sequence covers the long miss, and
// a randomized phase compares against a transaction-level reference model.
// -----------------------------------------------------------------------------
module tb_dmem_port_arbiter;

    localparam int AW = 10;
    localparam int DW = 32;

    typedef struct {
        logic          rst;
        logic          crd;
        logic          cwr;
        logic [AW-1:0] caddr;
        logic [DW-1:0] cwd;
        logic          dreq;
        logic          dwe;
        logic [AW-1:0] daddr;
        logic [DW-1:0] dwd;
        logic          mst;
        logic [DW-1:0] mrd;
        logic          eSt;
        logic          eRd;
        logic          eWr;
        logic [AW-1:0] eAddr;
        logic          eAck;
        int            eCnt;
        int            sel;
        logic [DW-1:0] eData;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst, c_rd, c_wr, d_req, d_we, m_stall;
    logic [AW-1:0] c_addr, d_addr;
    logic [DW-1:0] c_wdata, d_wdata, m_rdata;

    logic [DW-1:0] c_rdata, d_rdata, m_wdata;
    logic          c_stall, d_ack, m_read, m_write;
    logic [AW-1:0] m_addr;
    logic [15:0]   contention;

    logic [DW-1:0] s_c_rdata, s_d_rdata, s_m_wdata;
    logic          s_c_stall, s_d_ack, s_m_read, s_m_write;
    logic [AW-1:0] s_m_addr;
    logic [3:0]    s_contention;

    int nChecks = 0;
    int nFail   = 0;

    always #5 clk = ~clk;

    dmem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .c_rd(c_rd), .c_wr(c_wr), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_rdata(c_rdata), .c_stall(c_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .m_read(m_read), .m_write(m_write), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_stall(m_stall), .m_rdata(m_rdata), .contention(contention)
    );

    dmem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(4)) dutSmall (
        .clk(clk), .rst(rst),
        .c_rd(c_rd), .c_wr(c_wr), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_rdata(s_c_rdata), .c_stall(s_c_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(s_d_ack), .d_rdata(s_d_rdata),
        .m_read(s_m_read), .m_write(s_m_write), .m_addr(s_m_addr), .m_wdata(s_m_wdata),
        .m_stall(m_stall), .m_rdata(m_rdata), .contention(s_contention)
    );

    function automatic vec_t row(
        input logic r, input logic crd, input logic cwr, input logic [AW-1:0] caddr,
        input logic [DW-1:0] cwd, input logic dreq, input logic dwe, input logic [AW-1:0] daddr,
        input logic [DW-1:0] dwd, input logic mst, input logic [DW-1:0] mrd,
        input logic eSt, input logic eRd, input logic eWr, input logic [AW-1:0] eAddr,
        input logic eAck, input int eCnt, input int sel, input logic [DW-1:0] eData);
        vec_t v;
        v.rst = r; v.crd = crd; v.cwr = cwr; v.caddr = caddr; v.cwd = cwd;
        v.dreq = dreq; v.dwe = dwe; v.daddr = daddr; v.dwd = dwd;
        v.mst = mst; v.mrd = mrd;
        v.eSt = eSt; v.eRd = eRd; v.eWr = eWr; v.eAddr = eAddr;
        v.eAck = eAck; v.eCnt = eCnt; v.sel = sel; v.eData = eData;
        return v;
    endfunction

    // Drive one cycle of inputs on the falling edge, then let the
    // combinational outputs settle before anything is sampled.
    task automatic applyStimulus(input vec_t t);
        @(negedge clk);
        rst     = t.rst;
        c_rd    = t.crd;
        c_wr    = t.cwr;
        c_addr  = t.caddr;
        c_wdata = t.cwd;
        d_req   = t.dreq;
        d_we    = t.dwe;
        d_addr  = t.daddr;
        d_wdata = t.dwd;
        m_stall = t.mst;
        m_rdata = t.mrd;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    function automatic int capAt(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    // Reference model state: which master holds the port across a miss
    // (-1 none, 0 core, 1 DMA), the op being replayed, round-robin history,
    // blocked-cycle count, pending acknowledge, and last value put on the port.
    int            mBusy;
    logic          mPendWe;
    logic [AW-1:0] mPendAddr;
    logic [DW-1:0] mPendWd;
    int            mLast;
    int            mCnt;
    bit            mAck;
    logic [DW-1:0] mAckData;
    bit            mPortValid;
    logic [AW-1:0] mPortAddr;
    logic [DW-1:0] mPortWd;
    bit            dmaPend;

    task automatic modelReset();
        mBusy      = -1;
        mLast      = 1;
        mCnt       = 0;
        mAck       = 1'b0;
        mPortValid = 1'b0;
        dmaPend    = 1'b0;
    endtask

    // Predict this cycle's outputs from the model, compare, then advance
    // the model across the coming clock edge.
    task automatic modelCycle(input vec_t t);
        bit            cReq;
        int            owner;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
        cReq  = t.crd | t.cwr;
        we    = 1'b0;
        addr  = '0;
        wd    = '0;
        if (mBusy >= 0)               owner = mBusy;
        else if (cReq && t.dreq)      owner = (mLast == 0) ? 1 : 0;
        else if (cReq)                owner = 0;
        else if (t.dreq)              owner = 1;
        else                          owner = -1;

        if (mBusy >= 0) begin
            we = mPendWe; addr = mPendAddr; wd = mPendWd;
        end else if (owner == 0) begin
            we = t.cwr; addr = t.caddr; wd = t.cwd;
        end else if (owner == 1) begin
            we = t.dwe; addr = t.daddr; wd = t.dwd;
        end

        if (t.rst) begin
            checkOutput("rnd_rst_cstall", {31'd0, c_stall}, 32'd0);
            checkOutput("rnd_rst_mread", {31'd0, m_read}, 32'd0);
            checkOutput("rnd_rst_mwrite", {31'd0, m_write}, 32'd0);
        end else begin
            checkOutput("rnd_mread", {31'd0, m_read}, {31'd0, (owner >= 0) && !we});
            checkOutput("rnd_mwrite", {31'd0, m_write}, {31'd0, (owner >= 0) && we});
            if (owner >= 0) begin
                checkOutput("rnd_maddr", {22'd0, m_addr}, {22'd0, addr});
                checkOutput("rnd_mwdata", m_wdata, wd);
            end else if (mPortValid) begin
                checkOutput("rnd_maddr_hold", {22'd0, m_addr}, {22'd0, mPortAddr});
                checkOutput("rnd_mwdata_hold", m_wdata, mPortWd);
            end
            checkOutput("rnd_cstall", {31'd0, c_stall}, {31'd0, cReq && !(owner == 0 && !t.mst)});
            if (owner == 0 && !t.mst) checkOutput("rnd_crdata", c_rdata, t.mrd);
        end
        checkOutput("rnd_dack", {31'd0, d_ack}, {31'd0, mAck});
        if (mAck) checkOutput("rnd_drdata", d_rdata, mAckData);
        checkOutput("rnd_cnt16", {16'd0, contention}, capAt(mCnt, 65535));
        checkOutput("rnd_cnt4", {28'd0, s_contention}, capAt(mCnt, 15));

        if (t.rst) begin
            modelReset();
        end else begin
            if ((cReq && owner != 0) || (t.dreq && owner != 1)) mCnt++;
            mAck = 1'b0;
            if (owner >= 0) begin
                mPortValid = 1'b1;
                mPortAddr  = addr;
                mPortWd    = wd;
                if (t.mst) begin
                    mBusy = owner; mPendWe = we; mPendAddr = addr; mPendWd = wd;
                end else begin
                    mBusy = -1;
                    mLast = owner;
                    if (owner == 1) begin
                        mAck     = 1'b1;
                        mAckData = t.mrd;
                        dmaPend  = 1'b0;
                    end
                end
            end
        end
    endtask

    vec_t tbl[$];
    vec_t t;

    initial begin
        rst = 1'b1; c_rd = 1'b0; c_wr = 1'b0; c_addr = '0; c_wdata = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        m_stall = 1'b0; m_rdata = '0;
        repeat (2) @(posedge clk);

        // rst crd cwr caddr cwd dreq dwe daddr dwd mst mrd | eSt eRd eWr eAddr eAck eCnt sel eData
        // Reset state, with both requesters active.
        tbl.push_back(row(1,1,0,10'h010,0,1,0,10'h020,0,0,0,              0,0,0,0,0,0,0,0));
        // Core load hit.
        tbl.push_back(row(0,1,0,10'h010,0,0,0,0,0,0,32'hDEADBEEF,         0,1,0,10'h010,0,0,1,32'hDEADBEEF));
        // Core load miss, four stall cycles then completion.
        tbl.push_back(row(0,1,0,10'h010,0,0,0,0,0,1,32'h0,                1,1,0,10'h010,0,0,0,0));
        tbl.push_back(row(0,1,0,10'h010,0,0,0,0,0,1,32'h0,                1,1,0,10'h010,0,0,0,0));
        tbl.push_back(row(0,1,0,10'h010,0,0,0,0,0,1,32'h0,                1,1,0,10'h010,0,0,0,0));
        tbl.push_back(row(0,1,0,10'h010,0,0,0,0,0,1,32'h0,                1,1,0,10'h010,0,0,0,0));
        tbl.push_back(row(0,1,0,10'h010,0,0,0,0,0,0,32'h12345678,         0,1,0,10'h010,0,0,1,32'h12345678));
        // Tie straight after reset: core store first, DMA read next, then ack.
        tbl.push_back(row(1,0,0,0,0,0,0,0,0,0,0,                          0,0,0,0,0,0,0,0));
        tbl.push_back(row(0,0,1,10'h020,32'h11111111,1,0,10'h030,0,0,0,   0,0,1,10'h020,0,0,0,0));
        tbl.push_back(row(0,0,0,0,0,1,0,10'h030,0,0,32'hCAFEF00D,         0,1,0,10'h030,0,1,0,0));
        tbl.push_back(row(0,0,0,0,0,0,0,0,0,0,0,                          0,0,0,0,1,1,2,32'hCAFEF00D));
        // DMA write to the top word arrives during a three-cycle core miss.
        tbl.push_back(row(0,1,0,10'h040,0,0,0,0,0,1,0,                    1,1,0,10'h040,0,1,0,0));
        tbl.push_back(row(0,1,0,10'h040,0,1,1,10'h3FF,32'hA5A5A5A5,1,0,   1,1,0,10'h040,0,1,0,0));
        tbl.push_back(row(0,1,0,10'h040,0,1,1,10'h3FF,32'hA5A5A5A5,1,0,   1,1,0,10'h040,0,2,0,0));
        tbl.push_back(row(0,1,0,10'h040,0,1,1,10'h3FF,32'hA5A5A5A5,0,32'h0BADF00D, 0,1,0,10'h040,0,3,1,32'h0BADF00D));
        tbl.push_back(row(0,0,0,0,0,1,1,10'h3FF,32'hA5A5A5A5,0,0,         0,0,1,10'h3FF,0,4,0,0));
        tbl.push_back(row(0,0,0,0,0,0,0,0,0,0,0,                          0,0,0,0,1,4,0,0));
        // Reset while a DMA miss is outstanding: no completion, no ack.
        tbl.push_back(row(0,0,0,0,0,1,0,10'h155,0,1,0,                    0,1,0,10'h155,0,4,0,0));
        tbl.push_back(row(0,1,0,10'h200,0,1,0,10'h155,0,1,0,              1,1,0,10'h155,0,4,0,0));
        tbl.push_back(row(1,1,0,10'h200,0,1,0,10'h155,0,0,0,              0,0,0,0,0,5,0,0));
        tbl.push_back(row(0,0,0,0,0,0,0,0,0,0,0,                          0,0,0,0,0,0,0,0));
        tbl.push_back(row(0,0,0,0,0,0,0,0,0,0,0,                          0,0,0,0,0,0,0,0));
        // Load and store together: store wins. Then a tie with core last.
        tbl.push_back(row(0,1,1,10'h2AA,32'h5555AAAA,0,0,0,0,0,0,         0,0,1,10'h2AA,0,0,0,0));
        tbl.push_back(row(0,1,0,10'h001,0,1,0,10'h002,0,0,32'h77777777,   1,1,0,10'h002,0,0,0,0));
        tbl.push_back(row(0,1,0,10'h001,0,0,0,0,0,0,32'h0,                0,1,0,10'h001,1,1,2,32'h77777777));

        foreach (tbl[i]) begin
            applyStimulus(tbl[i]);
            checkOutput($sformatf("vec%0d_cstall", i), {31'd0, c_stall}, {31'd0, tbl[i].eSt});
            checkOutput($sformatf("vec%0d_mread", i), {31'd0, m_read}, {31'd0, tbl[i].eRd});
            checkOutput($sformatf("vec%0d_mwrite", i), {31'd0, m_write}, {31'd0, tbl[i].eWr});
            if (tbl[i].eRd || tbl[i].eWr)
                checkOutput($sformatf("vec%0d_maddr", i), {22'd0, m_addr}, {22'd0, tbl[i].eAddr});
            checkOutput($sformatf("vec%0d_dack", i), {31'd0, d_ack}, {31'd0, tbl[i].eAck});
            checkOutput($sformatf("vec%0d_cnt16", i), {16'd0, contention}, tbl[i].eCnt);
            checkOutput($sformatf("vec%0d_cnt4", i), {28'd0, s_contention}, capAt(tbl[i].eCnt, 15));
            if (tbl[i].sel == 1) checkOutput($sformatf("vec%0d_crdata", i), c_rdata, tbl[i].eData);
            if (tbl[i].sel == 2) checkOutput($sformatf("vec%0d_drdata", i), d_rdata, tbl[i].eData);
        end

        // Long core miss with the DMA waiting: the 4-bit counter must stop
        // at 15 while the 16-bit one keeps counting.
        t = '{default: '0};
        t.rst = 1'b1;
        applyStimulus(t);
        for (int k = 0; k <= 22; k++) begin
            int expCnt;
            t = '{default: '0};
            t.crd   = (k <= 20);
            t.caddr = 10'h0AB;
            t.dreq  = (k >= 1 && k <= 21);
            t.daddr = 10'h0CD;
            t.mst   = (k < 20);
            t.mrd   = 32'h600D0000 + k;
            applyStimulus(t);
            expCnt = (k == 0) ? 0 : capAt(k - 1, 20);
            checkOutput($sformatf("sat%0d_cnt16", k), {16'd0, contention}, expCnt);
            checkOutput($sformatf("sat%0d_cnt4", k), {28'd0, s_contention}, capAt(expCnt, 15));
            if (k <= 20) checkOutput($sformatf("sat%0d_cstall", k), {31'd0, c_stall}, {31'd0, k < 20});
            if (k == 22) checkOutput("sat_dack", {31'd0, d_ack}, 32'd1);
        end

        // Randomized traffic against the reference model. The DMA master
        // obeys its handshake: hold d_req until completion, then either drop
        // it in the ack cycle or present a fresh op.
        t = '{default: '0};
        t.rst = 1'b1;
        applyStimulus(t);
        modelReset();
        for (int n = 0; n < 2000; n++) begin
            int r;
            t.rst = ($urandom_range(0, 79) == 0);
            r     = $urandom_range(0, 3);
            t.crd = (r == 1) || (r == 3);
            t.cwr = (r == 2) || (r == 3);
            t.caddr = AW'($urandom);
            t.cwd   = $urandom;
            if (t.rst) begin
                dmaPend = 1'b0;
                t.dreq  = 1'b0;
            end else if (mAck) begin
                dmaPend = ($urandom_range(0, 2) == 0);
                if (dmaPend) begin
                    t.dwe = $urandom_range(0, 1); t.daddr = AW'($urandom); t.dwd = $urandom;
                end
                t.dreq = dmaPend;
            end else if (!dmaPend && $urandom_range(0, 3) == 0) begin
                dmaPend = 1'b1;
                t.dwe = $urandom_range(0, 1); t.daddr = AW'($urandom); t.dwd = $urandom;
                t.dreq = 1'b1;
            end else begin
                t.dreq = dmaPend;
            end
            t.mst = ($urandom_range(0, 9) < 3);
            t.mrd = $urandom;
            applyStimulus(t);
            modelCycle(t);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
